// File: rtl/traffic_phase_scheduler.sv
// -----------------------------------------------------------------------------
// traffic_phase_scheduler
//
// Demand-driven phase sequencer for the main/cross intersection. Main street
// rests green; the cross phase is only served after a request. The sequencer
// advances on the 1 Hz tick enable and runs on the 100 MHz system clock.
//
// Optional feature macro: PED_WALK_EN
//   defined   -> ped_btn input and walk output exist; ped_btn requests the
//                cross phase like cross_req, walk is lit during CROSS_G.
//   undefined -> neither port exists; only cross_req requests the cross phase.
//
// Ports
//   clk_100MHz  in   system clock
//   reset       in   synchronous, active-high reset
//   tick_1hz    in   one-cycle enable pulse, once per second
//   cross_req   in   cross-street vehicle sensor (level)
//   ped_btn     in   pedestrian request pulse          (PED_WALK_EN only)
//   main_st     out  {red,yellow,green} main street
//   cross_st    out  {red,yellow,green} cross street
//   phase       out  current state encoding
//   walk        out  pedestrian WALK lamp              (PED_WALK_EN only)
// -----------------------------------------------------------------------------
module traffic_phase_scheduler #(
   parameter int CNT_W       = 8,
   parameter int MAIN_MIN    = 10,
   parameter int CROSS_GREEN = 6,
   parameter int YELLOW      = 3,
   parameter int ALLRED      = 1
) (
   input  logic       clk_100MHz,
   input  logic       reset,
   input  logic       tick_1hz,
   input  logic       cross_req,
`ifdef PED_WALK_EN
   input  logic       ped_btn,
   output logic       walk,
`endif
   output logic [2:0] main_st,
   output logic [2:0] cross_st,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      MAIN_G  = 3'd0,
      MAIN_Y  = 3'd1,
      ALLRED1 = 3'd2,
      CROSS_G = 3'd3,
      CROSS_Y = 3'd4,
      ALLRED2 = 3'd5
   } state_t;

   // Last count value in each state; a timed state leaves on the tick where
   // cnt equals its last value, so it dwells exactly DURATION ticks.
   localparam logic [CNT_W-1:0] MAIN_LAST   = CNT_W'(MAIN_MIN - 1);
   localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW - 1);
   localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED - 1);
   localparam logic [CNT_W-1:0] CROSS_LAST  = CNT_W'(CROSS_GREEN - 1);

   localparam logic [2:0] LAMP_RED    = 3'b100;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;
   localparam logic [2:0] LAMP_GREEN  = 3'b001;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             pending, pending_nxt;
   logic             req_now;

`ifdef PED_WALK_EN
   assign req_now = cross_req | ped_btn;
`else
   assign req_now = cross_req;
`endif

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         state   <= MAIN_G;
         cnt     <= '0;
         pending <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         pending <= pending_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      pending_nxt = pending | req_now;

      case (state)
         MAIN_G: begin
            if (tick_1hz) begin
               if (cnt == MAIN_LAST) begin
                  // Request arriving on the tick cycle itself still counts.
                  if (pending | req_now) begin
                     state_nxt = MAIN_Y;
                     cnt_nxt   = '0;
                  end
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         MAIN_Y: begin
            if (tick_1hz) begin
               if (cnt == YELLOW_LAST) begin
                  state_nxt = ALLRED1;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         ALLRED1: begin
            if (tick_1hz) begin
               if (cnt == ALLRED_LAST) begin
                  state_nxt = CROSS_G;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         CROSS_G: begin
            if (tick_1hz) begin
               if (cnt == CROSS_LAST) begin
                  state_nxt = CROSS_Y;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         CROSS_Y: begin
            if (tick_1hz) begin
               if (cnt == YELLOW_LAST) begin
                  state_nxt = ALLRED2;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         ALLRED2: begin
            if (tick_1hz) begin
               if (cnt == ALLRED_LAST) begin
                  state_nxt = MAIN_G;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         default: begin
            // Unused encodings recover straight to main green.
            state_nxt = MAIN_G;
            cnt_nxt   = '0;
         end
      endcase

      // Serving the cross phase consumes the outstanding request; anything
      // arriving later in the cross phase queues the next round.
      if ((state_nxt == CROSS_G) && (state != CROSS_G)) begin
         pending_nxt = 1'b0;
      end
   end

   // Lamp decode straight from the state register.
   always_comb begin
      main_st  = LAMP_RED;
      cross_st = LAMP_RED;
      phase    = state;
      case (state)
         MAIN_G:  main_st  = LAMP_GREEN;
         MAIN_Y:  main_st  = LAMP_YELLOW;
         CROSS_G: cross_st = LAMP_GREEN;
         CROSS_Y: cross_st = LAMP_YELLOW;
         default: begin
            main_st  = LAMP_RED;
            cross_st = LAMP_RED;
         end
      endcase
   end

`ifdef PED_WALK_EN
   assign walk = (state == CROSS_G);
`endif

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
module tb_traffic_phase_scheduler;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick_1hz = 1'b0;
   logic       cross_req = 1'b0;
   logic [2:0] main_st, cross_st, phase;
`ifdef PED_WALK_EN
   logic       ped_btn = 1'b0;
   logic       walk;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   traffic_phase_scheduler dut (
      .clk_100MHz (clk),
      .reset      (reset),
      .tick_1hz   (tick_1hz),
      .cross_req  (cross_req),
`ifdef PED_WALK_EN
      .ped_btn    (ped_btn),
      .walk       (walk),
`endif
      .main_st    (main_st),
      .cross_st   (cross_st),
      .phase      (phase)
   );

   // Hand-written lamp table for each phase code.
   function automatic logic [2:0] exp_main(input logic [2:0] p);
      case (p)
         3'd0:    return 3'b001;
         3'd1:    return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

   function automatic logic [2:0] exp_cross(input logic [2:0] p);
      case (p)
         3'd3:    return 3'b001;
         3'd4:    return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

   // Phase after tick t for a request present from reset release.
   function automatic logic [2:0] exp_cycle(input int t);
      if (t < 10)       return 3'd0;
      else if (t < 13)  return 3'd1;
      else if (t == 13) return 3'd2;
      else if (t < 20)  return 3'd3;
      else if (t < 23)  return 3'd4;
      else if (t == 23) return 3'd5;
      else if (t < 34)  return 3'd0;
      else              return 3'd1;
   endfunction

   // One tick pulse, optionally with a one-cycle request on the same cycle,
   // followed by idle cycles; returns positioned on a falling edge.
   task automatic do_tick(input logic req_same_cycle);
      @(negedge clk);
      tick_1hz = 1'b1;
      if (req_same_cycle) cross_req = 1'b1;
      @(negedge clk);
      tick_1hz = 1'b0;
      if (req_same_cycle) cross_req = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      cross_req = 1'b1;
      repeat (2) @(negedge clk);
      tick_1hz = 1'b1;
      @(negedge clk);
      tick_1hz = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++;
      if (main_st !== 3'b001) begin
         tests_failed++;
         $display("FAIL reset_main: got %b expected 001", main_st);
      end
      tests_run++;
      if (cross_st !== 3'b100) begin
         tests_failed++;
         $display("FAIL reset_cross: got %b expected 100", cross_st);
      end
      tests_run++;
      if (phase !== 3'd0) begin
         tests_failed++;
         $display("FAIL reset_phase: got %0d expected 0", phase);
      end
`ifdef PED_WALK_EN
      tests_run++;
      if (walk !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_walk: got %b expected 0", walk);
      end
`endif
      cross_req = 1'b0;
      reset = 1'b0;
      // Ticks and requests seen under reset must leave no pending request.
      for (int t = 1; t <= 12; t++) do_tick(1'b0);
      tests_run++;
      if (phase !== 3'd0) begin
         tests_failed++;
         $display("FAIL reset_ignored: got phase %0d expected 0", phase);
      end
   endtask

   task automatic test_idle();
      do_reset();
      for (int t = 1; t <= 50; t++) begin
         do_tick(1'b0);
         tests_run++;
         if ({phase, main_st, cross_st} !== {3'd0, 3'b001, 3'b100}) begin
            tests_failed++;
            $display("FAIL idle_t%0d: got phase %0d main %b cross %b expected 0 001 100",
                     t, phase, main_st, cross_st);
         end
      end
      // Main-green count is saturated: a request on the tick cycle is served at once.
      do_tick(1'b1);
      tests_run++;
      if (phase !== 3'd1) begin
         tests_failed++;
         $display("FAIL idle_sat_req: got phase %0d expected 1", phase);
      end
   endtask

   task automatic test_cross_cycle();
      do_reset();
      cross_req = 1'b1;
      for (int t = 1; t <= 34; t++) begin
         do_tick(1'b0);
         tests_run++;
         if ({phase, main_st, cross_st} !==
             {exp_cycle(t), exp_main(exp_cycle(t)), exp_cross(exp_cycle(t))}) begin
            tests_failed++;
            $display("FAIL cycle_t%0d: got phase %0d main %b cross %b expected %0d %b %b",
                     t, phase, main_st, cross_st, exp_cycle(t),
                     exp_main(exp_cycle(t)), exp_cross(exp_cycle(t)));
         end
         tests_run++;
         if (main_st[2] !== 1'b1 && cross_st[2] !== 1'b1) begin
            tests_failed++;
            $display("FAIL cycle_conflict_t%0d: got main %b cross %b expected one red",
                     t, main_st, cross_st);
         end
      end
      cross_req = 1'b0;
   endtask

   task automatic test_latched_req();
      do_reset();
      for (int t = 1; t <= 14; t++) do_tick(1'b0);
      tests_run++;
      if (phase !== 3'd0) begin
         tests_failed++;
         $display("FAIL latch_before: got phase %0d expected 0", phase);
      end
      @(negedge clk);
      cross_req = 1'b1;
      @(negedge clk);
      cross_req = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if (phase !== 3'd0) begin
         tests_failed++;
         $display("FAIL latch_hold: got phase %0d expected 0", phase);
      end
      do_tick(1'b0);
      tests_run++;
      if ({phase, main_st} !== {3'd1, 3'b010}) begin
         tests_failed++;
         $display("FAIL latch_served: got phase %0d main %b expected 1 010", phase, main_st);
      end
   endtask

   task automatic test_same_cycle();
      do_reset();
      for (int t = 1; t <= 9; t++) do_tick(1'b0);
      do_tick(1'b1);
      tests_run++;
      if (phase !== 3'd1) begin
         tests_failed++;
         $display("FAIL same_cycle_t10: got phase %0d expected 1", phase);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      cross_req = 1'b1;
      for (int t = 1; t <= 16; t++) do_tick(1'b0);
      cross_req = 1'b0;
      tests_run++;
      if (phase !== 3'd3) begin
         tests_failed++;
         $display("FAIL mid_in_cross: got phase %0d expected 3", phase);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      tests_run++;
      if ({phase, main_st, cross_st} !== {3'd0, 3'b001, 3'b100}) begin
         tests_failed++;
         $display("FAIL mid_reset: got phase %0d main %b cross %b expected 0 001 100",
                  phase, main_st, cross_st);
      end
      // Pending raised during CROSS_G must be gone after reset.
      for (int t = 1; t <= 12; t++) do_tick(1'b0);
      tests_run++;
      if (phase !== 3'd0) begin
         tests_failed++;
         $display("FAIL mid_pending: got phase %0d expected 0", phase);
      end
   endtask

`ifdef PED_WALK_EN
   task automatic test_walk();
      do_reset();
      @(negedge clk);
      ped_btn = 1'b1;
      @(negedge clk);
      ped_btn = 1'b0;
      for (int t = 1; t <= 24; t++) begin
         do_tick(1'b0);
         tests_run++;
         if ({walk, cross_st} !== ((t >= 14 && t <= 19) ? {1'b1, 3'b001} : {1'b0, cross_st[2] ? 3'b100 : 3'b010})) begin
            tests_failed++;
            $display("FAIL walk_t%0d: got walk %b cross %b", t, walk, cross_st);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_idle();
      test_cross_cycle();
      test_latched_req();
      test_same_cycle();
      test_reset_mid();
`ifdef PED_WALK_EN
      test_walk();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
